// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM-stage controller: opcodes, FSM state
// encoding, access-size codes and opcode-to-size helpers.
package mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Unknown opcodes that still request an access fall back to a word.
  function automatic size_t op_size(input logic [5:0] op);
    size_t sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      default:              sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic op_unsigned(input logic [5:0] op);
    return (op == OP_LBU) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master)
// and the data memory (slave).
interface mem_stage_ctrl_if #(parameter int B = 32);
  logic         dmem_req;
  logic         dmem_we;
  logic [B-1:0] dmem_addr;
  logic [B-1:0] dmem_wdata;
  logic [3:0]   dmem_be;
  logic         dmem_ack;
  logic [B-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl_load_align.sv
// Load lane select and sign/zero extension (little-endian lanes).
module mem_load_align
  import mem_pkg::*;
#(
  parameter int B = 32
) (
  input  logic [B-1:0] rdata_i,
  input  logic [1:0]   lane_i,
  input  size_t        size_i,
  input  logic         unsigned_i,
  output logic [B-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, then extend it to the full width.
  always_comb begin
    case (lane_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_BYTE: data_o = unsigned_i ? {{(B-8){1'b0}}, byte_sel}
                                   : {{(B-8){byte_sel[7]}}, byte_sel};
      SZ_HALF: data_o = unsigned_i ? {{(B-16){1'b0}}, half_sel}
                                   : {{(B-16){half_sel[15]}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: branch/jump resolution, data-memory access FSM
// with variable-latency handshake and pipeline stall, MEM/WB register.
// Optional misaligned-access trap enabled by MEM_MISALIGN_CHECK_EN.
//
// state   | meaning
// IDLE    | no access in flight; capture bus fields when an access arrives
// REQ     | dmem_req high, bus fields held until dmem_ack
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int B = 32,
  parameter int W = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [B-1:0]  alu_result_in,
  input  logic [B-1:0]  r_data2_in,
  input  logic [W-1:0]  mux_RegDst_in,
  input  logic [B-1:0]  add_result_in,
  input  logic [B-1:0]  pc_jump_in,
  input  logic          zero_in,
  input  logic          wb_RegWrite_in,
  input  logic          wb_MemtoReg_in,
  input  logic          m_Jump_in,
  input  logic          m_Branch_in,
  input  logic          m_BranchNot_in,
  input  logic          m_MemRead_in,
  input  logic          m_MemWrite_in,
  input  logic [5:0]    opcode_in,
  mem_stage_ctrl_if.master dmem,
  output logic          stall_out,
  output logic          pc_src_out,
  output logic [B-1:0]  pc_target_out,
  output logic [B-1:0]  read_data_out,
  output logic [B-1:0]  alu_result_out,
  output logic [W-1:0]  mux_RegDst_out,
  output logic          wb_RegWrite_out,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic          misalign_out,
`endif
  output logic          wb_MemtoReg_out
);

  state_t       state_q;
  logic         req_q, we_q;
  logic [B-1:0] addr_q, wdata_q;
  logic [3:0]   be_q;
  logic [1:0]   lane_q;
  size_t        size_q;
  logic         uns_q;

  logic [B-1:0] rdata_ext;
  logic [B-1:0] alu_q, read_q;
  logic [W-1:0] regdst_q;
  logic         regwrite_q, memtoreg_q;

  logic         acc, mis_c, ack_c;
  size_t        size_c;
  logic [3:0]   be_c;
  logic [B-1:0] wdata_c;

  assign acc    = m_MemRead_in | m_MemWrite_in;
  assign size_c = op_size(opcode_in);
  assign ack_c  = (state_q == ST_REQ) & dmem.dmem_ack;

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis_c = acc & (state_q == ST_IDLE) &
                 (((size_c == SZ_HALF) & alu_result_in[0]) |
                  ((size_c == SZ_WORD) & (|alu_result_in[1:0])));
`else
  assign mis_c = 1'b0;
`endif

  assign stall_out = ((state_q == ST_IDLE) & acc & ~mis_c) |
                     ((state_q == ST_REQ) & ~dmem.dmem_ack);

  assign pc_src_out    = m_Jump_in | (m_Branch_in & zero_in) | (m_BranchNot_in & ~zero_in);
  assign pc_target_out = m_Jump_in ? pc_jump_in : add_result_in;

  // Store lane replication and byte enables; reads always enable all lanes.
  always_comb begin
    case (size_c)
      SZ_BYTE: begin
        be_c    = 4'b0001 << alu_result_in[1:0];
        wdata_c = {4{r_data2_in[7:0]}};
      end
      SZ_HALF: begin
        be_c    = alu_result_in[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{r_data2_in[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = r_data2_in;
      end
    endcase
    if (!m_MemWrite_in) be_c = 4'b1111;
  end

  // Access FSM with registered bus outputs held for the whole REQ phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      lane_q  <= '0;
      size_q  <= SZ_WORD;
      uns_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc && !mis_c) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            we_q    <= m_MemWrite_in;
            addr_q  <= {alu_result_in[B-1:2], 2'b00};
            wdata_q <= wdata_c;
            be_q    <= be_c;
            lane_q  <= alu_result_in[1:0];
            size_q  <= size_c;
            uns_q   <= op_unsigned(opcode_in);
          end
        end
        ST_REQ: begin
          if (dmem.dmem_ack) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;

  mem_load_align #(.B(B)) u_align (
    .rdata_i    (dmem.dmem_rdata),
    .lane_i     (lane_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (rdata_ext)
  );

  // MEM/WB register: bubble while stalled, load data captured on ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q      <= '0;
      regdst_q   <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      read_q     <= '0;
    end else begin
      if (stall_out) begin
        alu_q      <= '0;
        regdst_q   <= '0;
        regwrite_q <= 1'b0;
        memtoreg_q <= 1'b0;
      end else begin
        alu_q      <= alu_result_in;
        regdst_q   <= mux_RegDst_in;
        regwrite_q <= wb_RegWrite_in & ~mis_c;
        memtoreg_q <= wb_MemtoReg_in;
      end
      if (ack_c) read_q <= rdata_ext;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_q;

  // One-cycle misalignment flag, aligned with the MEM/WB update.
  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= mis_c;
  end

  assign misalign_out = misalign_q;
`endif

  assign read_data_out   = read_q;
  assign alu_result_out  = alu_q;
  assign mux_RegDst_out  = regdst_q;
  assign wb_RegWrite_out = regwrite_q;
  assign wb_MemtoReg_out = memtoreg_q;

endmodule
